mem_arbiter: RTL

- Shares one single-port, variable-latency unified memory between instruction fetch (IF requester) and load/store (data requester, MEM stage) of the 5-stage core.
- Sequences each access with a req/ack handshake.
- Generates o_stall towards the hazard logic so the pipeline freezes while an access is outstanding.
- Data has priority; a deferred fetch wins the next arbitration.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, data port and the memory side.
// The master modport is the arbiter; the slave modport is the core/memory environment.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic [DATA_WIDTH-1:0] o_if_rdata;
  logic                  o_if_valid;

  logic                  i_d_req;
  logic                  i_d_we;
  logic [ADDR_WIDTH-1:0] i_d_addr;
  logic [DATA_WIDTH-1:0] i_d_wdata;
  logic [3:0]            i_d_be;
  logic [DATA_WIDTH-1:0] o_d_rdata;
  logic                  o_d_valid;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [3:0]            o_mem_be;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  logic                  o_stall;
  logic                  o_err;

  modport master (
    input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  i_mem_ack, i_mem_rdata,
    output o_if_rdata, o_if_valid, o_d_rdata, o_d_valid,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output o_stall, o_err
  );

  modport slave (
    output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output i_mem_ack, i_mem_rdata,
    input  o_if_rdata, o_if_valid, o_d_rdata, o_d_valid,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  o_stall, o_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port, variable-latency unified memory.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without an ack.
module mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t state;
  state_t next_state;
  logic   last_grant;   // 0 = fetch served last, 1 = data served last
  logic   grant_d;
  logic   grant_if;
  logic   waiting;
  logic   timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Data wins unless both request and data was the last one served.
  assign grant_d  = bus.i_d_req & (~bus.i_if_req | ~last_grant);
  assign grant_if = bus.i_if_req & ~grant_d;
  assign waiting  = (state == FETCH) || (state == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Every FETCH/DATA is entered from IDLE, so clearing there starts each access at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout = waiting && !bus.i_mem_ack && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          next_state = DATA;
        end else if (grant_if) begin
          next_state = FETCH;
        end
      end
      FETCH, DATA: begin
        if (bus.i_mem_ack || timeout) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant      <= 1'b0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_mem_be    <= '0;
      bus.o_if_rdata  <= '0;
      bus.o_if_valid  <= 1'b0;
      bus.o_d_rdata   <= '0;
      bus.o_d_valid   <= 1'b0;
      bus.o_err       <= 1'b0;
    end else begin
      bus.o_if_valid <= 1'b0;
      bus.o_d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            last_grant      <= 1'b1;
            bus.o_mem_req   <= 1'b1;
            bus.o_mem_we    <= bus.i_d_we;
            bus.o_mem_addr  <= bus.i_d_addr;
            bus.o_mem_wdata <= bus.i_d_wdata;
            bus.o_mem_be    <= bus.i_d_be;
          end else if (grant_if) begin
            last_grant      <= 1'b0;
            bus.o_mem_req   <= 1'b1;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= bus.i_if_addr;
            bus.o_mem_wdata <= '0;
            bus.o_mem_be    <= 4'hF;
          end
        end
        FETCH, DATA: begin
          // An aborted access still completes with a valid pulse, carrying zero data.
          if (bus.i_mem_ack || timeout) begin
            bus.o_mem_req <= 1'b0;
            bus.o_err     <= bus.o_err | timeout;
            if (state == FETCH) begin
              bus.o_if_rdata <= timeout ? '0 : bus.i_mem_rdata;
              bus.o_if_valid <= 1'b1;
            end else begin
              bus.o_d_rdata  <= timeout ? '0 : bus.i_mem_rdata;
              bus.o_d_valid  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_stall = (bus.i_if_req & ~bus.o_if_valid) | (bus.i_d_req & ~bus.o_d_valid);

endmodule
